// File: rtl/mult_share_arbiter_if.sv
// Requester and result handshake bundle for mult_share_arbiter.
// Master drives operand requests and accepts results; slave is the arbiter.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [20:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one sign-magnitude 8x8 multiplier (Mult8_2) across NREQ lanes.
// Two register stages (operands, tagged product); stalls only on res_ready backpressure and drains without bubbles.
module mult8_2 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [20:0] p
);
  logic [15:0] acc;

  // Shift-add over the 7 magnitude bits; the sign is handled separately.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) acc = acc + (16'(a[6:0]) << i);
    end
  end

  assign p = {a[7] ^ b[7], 4'b0000, acc};
endmodule

module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_share_arbiter_if.slave bus
);
  localparam int CW = IDW + 1;

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ)) begin : g_bad_param
    $error("mult_share_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
  end

  logic [IDW-1:0]  ptr;
  logic            s1_valid;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic [IDW-1:0]  s1_id;
  logic            s2_valid;
  logic [20:0]     s2_data;
  logic [IDW-1:0]  s2_id;
  logic            adv1;
  logic            adv2;
  logic            gnt_hit;
  logic [IDW-1:0]  gnt_idx;
  logic [CW-1:0]   cand;
  logic [NREQ-1:0] gnt_vec;
  logic            xfer;
  logic [7:0]      gnt_a;
  logic [7:0]      gnt_b;
  logic [20:0]     prod;

  assign adv2 = bus.res_ready | ~s2_valid;
  assign adv1 = adv2 | ~s1_valid;

  // First valid requester at or after ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!gnt_hit && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign xfer = gnt_hit & adv1;

  always_comb begin
    gnt_vec = '0;
    if (xfer) gnt_vec[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt_vec;
  assign gnt_a         = bus.req_a[8*gnt_idx +: 8];
  assign gnt_b         = bus.req_b[8*gnt_idx +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a  <= gnt_a;
        s1_b  <= gnt_b;
        s1_id <= gnt_idx;
      end
    end
  end

  mult8_2 u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // Data only moves with a valid product so res_data stays put across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= prod;
        s2_id   <= s1_id;
      end
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_data;
  assign bus.res_id    = s2_id;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: reset, sign/magnitude products, round robin,
// backpressure hold/drain and asynchronous reset in flight.
module tb_mult_share_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mult_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  mult_share_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Backpressure table: per cycle inputs and expected outputs (requester 1 streaming).
  logic [3:0]  bp_v    [0:8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic [31:0] bp_a    [0:8] = '{32'h0A00, 32'h0B00, 32'h0C00, 32'h0C00, 32'h0C00, 32'h0C00, 32'h0, 32'h0, 32'h0};
  logic        bp_rr   [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0]  bp_rdy  [0:8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic        bp_vld  [0:8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [20:0] bp_dat  [0:8] = '{21'h0, 21'h0, 21'h1E, 21'h1E, 21'h1E, 21'h1E, 21'h21, 21'h24, 21'h0};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input logic rr);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = rr;
    @(negedge clk);
  endtask

  task automatic check_res(input string tag, input logic vld, input logic [1:0] id, input logic [20:0] dat);
    check_val({tag, "_vld"}, bus.res_valid, vld);
    if (vld) begin
      check_val({tag, "_id"}, bus.res_id, id);
      check_val({tag, "_dat"}, bus.res_data, dat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;

    // Reset state
    #12;
    check_val("rst_vld", bus.res_valid, 0);
    check_val("rst_dat", bus.res_data, 0);
    check_val("rst_id", bus.res_id, 0);
    check_val("rst_rdy", bus.req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin, all requesters valid: grants 0,1,2,3,0,1; product = 2*(id+1)
    for (int c = 0; c < 9; c++) begin
      drive((c < 6) ? 4'b1111 : 4'b0000, 32'h04030201, 32'h02020202, 1'b1);
      check_val("rr_rdy", bus.req_ready, (c < 6) ? (32'd1 << (c % 4)) : 32'd0);
      check_res("rr", (c >= 2 && c < 8), 2'((c - 2) % 4), 21'(2 * ((c - 2) % 4 + 1)));
    end

    // Grant to 1, then only 0 and 3 valid: 3 then 0
    drive(4'b0010, 32'h04030201, 32'h02020202, 1'b1);
    check_val("rr2_rdy1", bus.req_ready, 4'b0010);
    drive(4'b1001, 32'h04030201, 32'h02020202, 1'b1);
    check_val("rr2_rdy3", bus.req_ready, 4'b1000);
    drive(4'b1001, 32'h04030201, 32'h02020202, 1'b1);
    check_val("rr2_rdy0", bus.req_ready, 4'b0001);
    check_res("rr2_r1", 1'b1, 2'd1, 21'd4);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("rr2_r3", 1'b1, 2'd3, 21'd8);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("rr2_r0", 1'b1, 2'd0, 21'd2);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("rr2_idle", 1'b0, 2'd0, 21'd0);

    // Single request from requester 0: 3*5
    drive(4'b0001, 32'h03, 32'h05, 1'b1);
    check_val("one_rdy", bus.req_ready, 4'b0001);
    check_res("one_c0", 1'b0, 2'd0, 21'd0);
    drive(4'b0000, 32'h03, 32'h05, 1'b1);
    check_val("one_rdy_off", bus.req_ready, 4'b0000);
    check_res("one_c1", 1'b0, 2'd0, 21'd0);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("one_res", 1'b1, 2'd0, 21'h00000F);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("one_done", 1'b0, 2'd0, 21'd0);

    // Requester 2: sign, maximum magnitude, negative zero
    drive(4'b0100, 32'h00830000, 32'h00050000, 1'b1);
    check_val("sgn_rdy0", bus.req_ready, 4'b0100);
    drive(4'b0100, 32'h00FF0000, 32'h007F0000, 1'b1);
    check_val("sgn_rdy1", bus.req_ready, 4'b0100);
    drive(4'b0100, 32'h00800000, 32'h00050000, 1'b1);
    check_val("sgn_rdy2", bus.req_ready, 4'b0100);
    check_res("sgn_neg", 1'b1, 2'd2, 21'h10000F);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("sgn_max", 1'b1, 2'd2, 21'h103F01);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("sgn_nzero", 1'b1, 2'd2, 21'h100000);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("sgn_done", 1'b0, 2'd0, 21'd0);

    // Backpressure: requester 1 streams a*3, res_ready low for 5 cycles
    for (int c = 0; c < 9; c++) begin
      drive(bp_v[c], bp_a[c], 32'h0300, bp_rr[c]);
      check_val("bp_rdy", bus.req_ready, bp_rdy[c]);
      check_res("bp", bp_vld[c], 2'd1, bp_dat[c]);
    end

    // Fill both stages, then reset asynchronously between edges
    drive(4'b0001, 32'h02, 32'h02, 1'b0);
    check_val("ar_rdy0", bus.req_ready, 4'b0001);
    drive(4'b0001, 32'h03, 32'h02, 1'b0);
    check_val("ar_rdy1", bus.req_ready, 4'b0001);
    drive(4'b0001, 32'h03, 32'h02, 1'b0);
    check_val("ar_full_rdy", bus.req_ready, 4'b0000);
    check_res("ar_full", 1'b1, 2'd0, 21'd4);
    #2;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #1;
    check_val("ar_vld_drop", bus.res_valid, 0);
    check_val("ar_dat_clr", bus.res_data, 0);
    check_val("ar_rdy_clr", bus.req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 32'h0, 32'h0, 1'b1);
      check_val("ar_quiet", bus.res_valid, 0);
    end
    drive(4'b1111, 32'h04030201, 32'h02020202, 1'b1);
    check_val("ar_ptr0", bus.req_ready, 4'b0001);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("ar_c1", 1'b0, 2'd0, 21'd0);
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    check_res("ar_res", 1'b1, 2'd0, 21'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one Mult8_2 sign-magnitude 8x8 multiplier among NREQ requesters (neuron lanes) with round-robin arbitration.
- Two-stage pipeline:
  - operand register
  - result register with requester tag
- Valid/ready handshake on every requester port and on the result port.
- Full backpressure; throughput of one product per cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester tag; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_a  input  8*NREQ  operand a, sign-magnitude; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  operand b, same packing.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- res_valid  output  1  result valid.
- res_data  output  21  Mult8_2 product format.
- res_id  output  IDW  index of the requester that owns res_data.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, s2_valid=0, res_valid=0, res_data=0, res_id=0, req_ready=0.
  - Round-robin pointer=0, so requester 0 has top priority.
- Operand format:
  - bit7 = sign, bits6:0 = magnitude.
- Result format:
  - res_data[20] = a[7] XOR b[7].
  - res_data[19:16] = 0.
  - res_data[15:0] = a[6:0] * b[6:0].
  - Computed by one Mult8_2 instance driven from the stage-1 registers.
  - Negative zero (sign=1, magnitude 0) passes through unchanged.
- Pipeline control:
  - adv2 = res_ready OR NOT s2_valid.
  - adv1 = adv2 OR NOT s1_valid.
  - Stage 1 loads the granted operands when adv1 is high.
  - Stage 2 loads the Mult8_2 output and tag when adv2 is high.
  - s2_valid is loaded from s1_valid.
- Grant:
  - Only when adv1 is high.
  - Goes to the first requester with req_valid set, searching from pointer upward with wrap-around (NREQ-1 wraps to 0).
  - req_ready is combinational from req_valid, pointer and adv1; it is never high for a requester whose req_valid is low.
  - At most one bit is set.
- Pointer update:
  - After a transfer from requester g, pointer = g+1 mod NREQ.
  - No transfer leaves the pointer unchanged.
- Latency: operands accepted at edge N appear on res_valid/res_data at edge N+1, observable in the cycle after it. One cycle of register delay per stage.
- Backpressure:
  - While res_valid=1 and res_ready=0, res_data and res_id hold stable.
  - Stage 1 holds if occupied.
  - Once both stages are full, req_ready=0 for all requesters.
- Simultaneous events:
  - When res_ready rises with both stages full, the output drains, stage 1 moves to stage 2 and a new grant issues in the same cycle, so no bubble is inserted.
- req_valid drop: a requester may drop req_valid without a transfer; no state is affected.
- Reset mid-operation: all in-flight products are discarded and no res_valid pulse follows. The pointer returns to 0.
- The sequential logic contains no combinational path from res_ready to res_valid.

Test Plan:
- Single request: requester 0 sends a=8'h03, b=8'h05, res_ready=1 -> req_ready=4'b0001 for one cycle; two cycles later res_valid=1, res_data=21'h00000F, res_id=0.
- Signs and max: requester 2 sends a=8'h83, b=8'h05 -> res_data=21'h10000F, res_id=2. Then a=8'hFF, b=8'h7F -> 21'h103F01. Then a=8'h80, b=8'h05 -> 21'h100000 (negative zero).
- Round robin:
  - All four req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows the same order, one result per cycle.
  - After a grant to 1, only requesters 0 and 3 valid -> next grant 3, then 0.
- Backpressure: stream from requester 1, res_ready=0 for 5 cycles -> res_data/res_id frozen; req_ready=0 after 2 accepts. When res_ready=1 is restored -> results drain in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 asynchronously while both stages are valid -> res_valid drops immediately (no clock edge needed). After release with no requests -> res_valid stays 0; first grant goes to requester 0.
